// File: rtl/synth_seq_pkg.sv
// Shared definitions for the sequence player.
//   ADDR_W          sequence memory address width
//   NOTE_W          notes per step (one enable bit per note)
//   SEQ_LEN_DEFAULT default sequence length in steps
//   player_state_t  playback FSM states
package synth_seq_pkg;

  localparam int ADDR_W          = 11;
  localparam int NOTE_W          = 5;
  localparam int SEQ_LEN_DEFAULT = 1875;

  // ST_REQ : ram_addr presented to the memory
  // ST_CAPT: ram_data valid, captured into notes at cycle end
  // ST_WAIT: holding notes, waiting for the next tick
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAPT,
    ST_WAIT
  } player_state_t;

endpackage

// File: rtl/sequence_player_if.sv
// Sequence memory read bus.
//   ram_addr  read address from the player
//   ram_data  read data, valid the cycle after ram_addr (registered read)
// Modports: master = player side, slave = memory side.
interface sequence_player_if #(
  parameter int ADDR_W = synth_seq_pkg::ADDR_W,
  parameter int NOTE_W = synth_seq_pkg::NOTE_W
);

  logic [ADDR_W-1:0] ram_addr;
  logic [NOTE_W-1:0] ram_data;

  modport master (output ram_addr, input  ram_data);
  modport slave  (input  ram_addr, output ram_data);

endinterface

// File: rtl/sequence_player.sv
// Step sequencer playback engine. Walks a note-mask memory one step per
// external tick, presenting each step's mask on notes.
//   clk      single clock, rising edge
//   reset    asynchronous, active-high
//   play     start request (IDLE only, needs length != 0, stop low)
//   stop     abort request, returns to IDLE without done
//   loop     1 = wrap to step 0 after the last step
//   tick     one-cycle step strobe
//   length   steps to play, latched on an accepted play
//   mem      sequence memory read bus (master side)
//   notes    registered note-enable mask for the current step
//   playing  high while not IDLE
//   done     one-cycle pulse when a non-looping pass completes
module sequence_player #(
  parameter int ADDR_W = synth_seq_pkg::ADDR_W,
  parameter int NOTE_W = synth_seq_pkg::NOTE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  stop,
  input  logic                  loop,
  input  logic                  tick,
  input  logic [ADDR_W-1:0]     length,
  sequence_player_if.master     mem,
  output logic [NOTE_W-1:0]     notes,
  output logic                  playing,
  output logic                  done
);

  import synth_seq_pkg::*;

  player_state_t     r_state;
  logic [ADDR_W-1:0] r_step;
  logic [ADDR_W-1:0] r_len;
  logic              r_pending;
  logic [NOTE_W-1:0] r_notes;
  logic              r_playing;
  logic              r_done;

  logic              w_last;

  assign w_last = (r_step == r_len - ADDR_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_len     <= '0;
      r_pending <= 1'b0;
      r_notes   <= '0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_step    <= '0;
        r_pending <= 1'b0;
        r_notes   <= '0;
        r_playing <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (play && !stop && (length != '0)) begin
              r_len     <= length;
              r_step    <= '0;
              r_pending <= 1'b0;
              r_playing <= 1'b1;
              r_state   <= ST_REQ;
            end
          end
          ST_REQ: begin
            // A tick during the fetch is remembered once; extra ticks drop.
            if (tick) r_pending <= 1'b1;
            r_state <= ST_CAPT;
          end
          ST_CAPT: begin
            if (tick) r_pending <= 1'b1;
            r_notes <= mem.ram_data;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (tick || r_pending) begin
              r_pending <= 1'b0;
              if (!w_last) begin
                r_step  <= r_step + ADDR_W'(1);
                r_state <= ST_REQ;
              end else if (loop) begin
                r_step  <= '0;
                r_state <= ST_REQ;
              end else begin
                // Step is cleared here so ram_addr reads 0 throughout IDLE.
                r_step    <= '0;
                r_notes   <= '0;
                r_done    <= 1'b1;
                r_playing <= 1'b0;
                r_state   <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign mem.ram_addr = r_step;
  assign notes        = r_notes;
  assign playing      = r_playing;
  assign done         = r_done;

endmodule

// File: tb/tb_sequence_player.sv
// Self-checking bench for sequence_player. The reference model is the
// step-sequence rule itself: at the k-th tick of a pass the held mask is
// mem[(k-1) mod length] and the address is (k-1) mod length.
module tb_sequence_player;

  localparam int AW = 11;
  localparam int NW = 5;

  logic          clk;
  logic          reset;
  logic          play;
  logic          stop;
  logic          loop;
  logic          tick;
  logic [AW-1:0] length;
  logic [NW-1:0] notes;
  logic          playing;
  logic          done;

  int unsigned   checks;
  int unsigned   errors;
  int unsigned   done_cnt;

  logic [NW-1:0] mem [0:(1<<AW)-1];

  sequence_player_if #(.ADDR_W(AW), .NOTE_W(NW)) mif ();

  sequence_player #(.ADDR_W(AW), .NOTE_W(NW)) dut (
    .clk     (clk),
    .reset   (reset),
    .play    (play),
    .stop    (stop),
    .loop    (loop),
    .tick    (tick),
    .length  (length),
    .mem     (mif.master),
    .notes   (notes),
    .playing (playing),
    .done    (done)
  );

  // Registered-read memory model.
  always @(posedge clk) mif.ram_data <= mem[mif.ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_playing"}, 32'(playing), 32'd0);
    chk({tag, "_notes"}, 32'(notes), 32'd0);
    chk({tag, "_addr"}, 32'(mif.ram_addr), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Start a pass and deliver nticks ticks spaced p cycles apart (p >= 3).
  // play/length are scrambled during playback; they must be ignored.
  task automatic play_ticks(input int unsigned len, input logic lp,
                            input int unsigned p, input int unsigned nticks);
    int unsigned exp_step;
    length = AW'(len);
    loop   = lp;
    play   = 1'b1;
    do_cycle();
    done_cnt = 0;
    for (int unsigned k = 1; k <= nticks; k++) begin
      repeat (p - 1) begin
        play   = 1'($urandom);
        length = AW'($urandom);
        done_cnt += 32'(done);
        do_cycle();
      end
      done_cnt += 32'(done);
      exp_step = (k - 1) % len;
      chk("tick_notes", 32'(notes), 32'(mem[exp_step]));
      chk("tick_addr", 32'(mif.ram_addr), exp_step);
      chk("tick_playing", 32'(playing), 32'd1);
      tick = 1'b1;
      do_cycle();
      tick = 1'b0;
    end
    play = 1'b0;
    chk("no_early_done", done_cnt, 32'd0);
  endtask

  task automatic finish_check();
    chk("end_done", 32'(done), 32'd1);
    chk("end_notes", 32'(notes), 32'd0);
    chk("end_playing", 32'(playing), 32'd0);
    chk("end_addr", 32'(mif.ram_addr), 32'd0);
    do_cycle();
    chk("end_done_pulse", 32'(done), 32'd0);
  endtask

  task automatic stop_check(input string tag);
    stop = 1'b1;
    do_cycle();
    stop = 1'b0;
    chk_idle(tag);
  endtask

  task automatic load_onehot();
    for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[0] = 5'b00001;
    mem[1] = 5'b00010;
    mem[2] = 5'b00100;
    mem[3] = 5'b01000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    play   = 1'b0;
    stop   = 1'b0;
    loop   = 1'b0;
    tick   = 1'b0;
    length = '0;
    load_onehot();

    // Reset applies before any clock edge.
    #2;
    chk_idle("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    do_cycle();

    // Four-step one-shot pass.
    play_ticks(4, 1'b0, 10, 4);
    finish_check();
    repeat (3) do_cycle();

    // Looping pass, ten ticks, wraps twice.
    play_ticks(4, 1'b1, 10, 10);
    do_cycle();
    chk("loop_no_done", done_cnt + 32'(done), 32'd0);
    stop_check("loop_stop");

    // Stop while holding step 2.
    play_ticks(4, 1'b0, 10, 2);
    repeat (3) do_cycle();
    chk("stop_pre_addr", 32'(mif.ram_addr), 32'd2);
    chk("stop_pre_notes", 32'(notes), 32'(mem[2]));
    stop_check("stop_s2");
    repeat (4) do_cycle();
    chk("stop_done_quiet", 32'(done), 32'd0);

    // Ticks during fetch and capture collapse into one pending step.
    length = 4;
    loop   = 1'b0;
    play   = 1'b1;
    do_cycle();
    play = 1'b0;
    tick = 1'b1;
    do_cycle();
    do_cycle();
    tick = 1'b0;
    chk("pend_notes0", 32'(notes), 32'(mem[0]));
    chk("pend_addr0", 32'(mif.ram_addr), 32'd0);
    do_cycle();
    chk("pend_addr1", 32'(mif.ram_addr), 32'd1);
    repeat (2) do_cycle();
    chk("pend_notes1", 32'(notes), 32'(mem[1]));
    repeat (6) do_cycle();
    chk("pend_noskip_addr", 32'(mif.ram_addr), 32'd1);
    chk("pend_noskip_notes", 32'(notes), 32'(mem[1]));
    stop_check("pend_stop");

    // Rejected starts.
    length = 0;
    play   = 1'b1;
    do_cycle();
    play = 1'b0;
    do_cycle();
    chk_idle("len0");
    length = 4;
    play   = 1'b1;
    stop   = 1'b1;
    do_cycle();
    play = 1'b0;
    stop = 1'b0;
    do_cycle();
    chk_idle("play_stop");

    // Asynchronous reset while holding step 3.
    play_ticks(4, 1'b0, 10, 3);
    repeat (3) do_cycle();
    chk("rst_pre_addr", 32'(mif.ram_addr), 32'd3);
    #3;
    reset = 1'b1;
    #1;
    chk_idle("async_rst");
    #1;
    reset = 1'b0;
    do_cycle();
    chk_idle("post_rst");
    play_ticks(4, 1'b0, 10, 4);
    finish_check();

    // Randomised passes over random memory contents.
    for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = NW'($urandom);
    for (int unsigned r = 0; r < 8; r++) begin
      int unsigned len;
      int unsigned p;
      logic        lp;
      len = (r == 0) ? 1 : $urandom_range(1, 12);
      p   = $urandom_range(3, 8);
      lp  = 1'($urandom);
      if (lp) begin
        play_ticks(len, 1'b1, p, $urandom_range(1, 3 * len));
        stop_check("rand_loop_stop");
      end else begin
        play_ticks(len, 1'b0, p, len);
        finish_check();
      end
      repeat (2) do_cycle();
    end

    // Full-length one-shot pass exercises the top address.
    play_ticks(2047, 1'b0, 3, 2047);
    finish_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter ADDR_W, 11, sequence memory address width.
REQ-002 Parameter NOTE_W, 5, notes per sequence step (one bit per note).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port play  input  1  start-playback request, sampled each cycle.
REQ-006 Port stop  input  1  abort-playback request, sampled each cycle.
REQ-007 Port loop  input  1  level; 1 = wrap to step 0 after last step instead of finishing.
REQ-008 Port tick  input  1  one-cycle step strobe (375 Hz sample rate), generated externally.
REQ-009 Port length  input  ADDR_W  number of steps to play (1..2047), sampled on accepted play.
REQ-010 Port ram_addr  output  ADDR_W  read address to the sequence memory.
REQ-011 Port ram_data  input  NOTE_W  sequence memory read data, valid the cycle after ram_addr is presented (registered read).
REQ-012 Port notes  output  NOTE_W  registered note-enable mask for the current step.
REQ-013 Port playing  output  1  high from accepted play until return to IDLE.
REQ-014 Port done  output  1  one-cycle pulse when a non-looping pass completes.

Function
REQ-015 States: IDLE, REQ (ram_addr driven), CAPT (ram_data valid), WAIT (holding notes, awaiting tick).
REQ-016 IDLE: play=1, stop=0, length!=0 -> latch length into len_r, step=0, go REQ; play with length=0 ignored.
REQ-017 ram_addr SHALL equal internal step register in every state; 0 in IDLE.
REQ-018 REQ -> CAPT unconditionally after one cycle.
REQ-019 CAPT: notes <= ram_data at cycle end; go WAIT; notes update exactly 2 cycles after entering REQ.
REQ-020 WAIT, tick=1 (or pending tick set), step != len_r-1: step <= step+1, go REQ.
REQ-021 WAIT, tick, step == len_r-1, loop=1: step <= 0, go REQ (wrap, no done).
REQ-022 WAIT, tick, step == len_r-1, loop=0: notes <= 0, done=1 for one cycle, go IDLE.
REQ-023 tick arriving in REQ or CAPT SHALL set a single pending flag; flag consumed on next WAIT cycle; further ticks while pending set are dropped (no step skipping).
REQ-024 stop=1 in any non-IDLE state: go IDLE next edge, notes <= 0, pending cleared, no done pulse.
REQ-025 stop and play both high: stop wins; remains/returns IDLE.
REQ-026 play while not IDLE SHALL be ignored; len_r unchanged by length changes mid-playback.
REQ-027 playing SHALL be high in REQ, CAPT, WAIT; low in IDLE.
REQ-028 step arithmetic ADDR_W-bit unsigned; len_r=1 plays step 0 repeatedly (loop) or once.

Reset
REQ-029 reset asynchronously forces state IDLE, step 0, len_r 0, pending 0, notes 0, playing 0, done 0, ram_addr 0.
REQ-030 reset mid-playback SHALL produce no done pulse; first play after reset release behaves as REQ-016.

Structure
REQ-031 Package synth_seq_pkg holds ADDR_W, NOTE_W, SEQ_LEN_DEFAULT=1875, and the player state enum.
REQ-032 No sub-module; tick generation lives in external seq_tick_gen; player is single flat FSM plus step counter.

Verification
REQ-033 Memory model preloaded steps 0..3 = 5'b00001,5'b00010,5'b00100,5'b01000; play with length=4, loop=0, tick every 10 cycles -> notes 00001,00010,00100,01000 in order, then notes 0, done one pulse, playing low.
REQ-034 Same load, loop=1, 10 ticks -> notes sequence wraps to 00001 after 01000, no done, ram_addr returns to 0.
REQ-035 stop asserted during WAIT at step 2 -> next cycle IDLE, notes 0, ram_addr 0, done stays 0.
REQ-036 tick asserted in cycle immediately after play (REQ) -> pending honoured: step 1 fetched right after step 0 captured; two ticks in REQ+CAPT advance only one step.
REQ-037 play with length=0 -> stays IDLE, playing 0; play+stop same cycle -> stays IDLE.
REQ-038 reset pulsed asynchronously (between clock edges) at step 3 -> all outputs 0 immediately, no done; subsequent play restarts at step 0.
